i2c_master_wb: RTL and testbench
================================

// Module: i2c_master_wb
// PURPOSE
//  Byte-level I2C bus master with an 8-bit Wishbone slave register interface.
//  Host programs prescaler/control, loads TXR, issues CR commands
//  (START/WRITE/READ/ACK/STOP); block drives open-drain SCL/SDA and flags completion via IF/interrupt.
//  Sits between a system-bus-to-Wishbone bridge and the board I2C pads.
// PARAMETERS
//  PRER_RST   16'hFFFF  prescaler reset value
// PORTS
//  wb_clk_i      in   1  single clock, all logic on rising edge
//  wb_rst_i      in   1  reset, synchronous, active-low; no asynchronous reset
//  wb_adr_i      in   3  register address
//  wb_dat_i      in   8  write data
//  wb_dat_o      out  8  read data (registered)
//  wb_we_i       in   1  1=write
//  wb_stb_i      in   1  strobe
//  wb_cyc_i      in   1  cycle valid
//  wb_ack_o      out  1  transfer acknowledge
//  wb_inta_o     out  1  interrupt, active-high
//  scl_pad_i     in   1  SCL line level;  scl_pad_o out 1 always 0;  scl_padoen_o out 1 0=drive low,1=release
//  sda_pad_i     in   1  SDA line level;  sda_pad_o out 1 always 0;  sda_padoen_o out 1 0=drive low,1=release
// BEHAVIOUR
//  Registers: 0 PRERlo, 1 PRERhi (R/W); 2 CTR[7]=EN,[6]=IEN (R/W); 3 W:TXR R:RXR; 4 W:CR R:SR; 5-7 read 0, writes ignored.
//  CR: [7]STA [6]STO [5]RD [4]WR [3]ACK(1=send NACK on read) [0]IACK. SR: [7]RxACK [6]Busy [5]AL [1]TIP [0]IF.
//  Reset: PRER=PRER_RST, CTR/TXR/RXR/CR/SR=0, wb_ack_o=0, wb_dat_o=0, wb_inta_o=0, both padoen=1.
//  WB: wb_ack_o <= stb&cyc&~ack -> 1 cycle after request, 1-cycle pulse; data written/latched on ack edge.
//  Commands accepted only when CTR.EN=1 and TIP=0; else CR write ignored (IACK always honoured).
//  Command: TIP=1 next cycle; sequence = [START if STA] -> byte (WR: send TXR MSB first, sample RxACK;
//   RD: shift into RXR, drive ACK bit) -> [STOP if STO]. On done: CR cmd bits clear, TIP=0, IF=1.
//  Bit timing: tick every PRER+1 clocks; bit = 5 ticks: T0 SCL low set SDA, T1 low, T2 release SCL,
//   T3 high (sample SDA at end), T4 SCL low. fSCL = fclk/(5*(PRER+1)); PRER=0 -> tick every clock.
//  START: SDA released,SCL released (2 ticks) -> SDA low (2 ticks) -> SCL low (1). Busy=1.
//  STOP: SDA low,SCL low -> SCL released (2 ticks) -> SDA released (2 ticks). Busy=0.
//  AL: while master releases SDA with SCL high but sda_pad_i=0 -> AL=1, IF=1, TIP=0, release both lines, abort.
//  Byte FSM: IDLE->START->WRITE/READ->ACK->STOP->IDLE; bit FSM as above. AL cleared by next command write.
//  IF cleared by IACK write; IACK and new completion same cycle -> IF=1. wb_inta_o <= IF & CTR.IEN.
//  Clearing EN mid-transfer: abort, release both lines, TIP=0, no IF. Reset mid-transfer: return to reset state.
// CONFIGURATION
//  CLK_STRETCH_EN: defined -> after releasing SCL, bit FSM stalls (tick counter held) until scl_pad_i=1
//   (slave clock stretching). Undefined -> SCL timing purely from prescaler, scl_pad_i ignored.
// TESTING
//  Reset: read adr0/1/2/4 -> 0xFF,0xFF,0x00,0x00; padoen=1; ack pulse exactly 1 cycle after stb.
//  Write PRERlo=0x27 then read -> 0x27; fclk 20MHz -> SCL period 200 clocks (100kHz).
//  CTR=0xC0,TXR=0x18,CR=0x90, slave ACKs: SDA falls with SCL high, bits 00011000, RxACK=0, IF=1, inta=1.
//  Same with no slave (SDA released on 9th bit) -> RxACK=1, Busy=1, IF=1.
//  CR=0x68 with slave driving 0xA5 -> RXR=0xA5, SDA released on 9th bit, STOP seen, Busy=0.
//  CR=0x01 -> IF=0, inta=0 next cycle; external SDA low during master '1' -> AL=1, IF=1.

Source files
------------

// File: rtl/i2c_master_wb.sv
// Byte-level I2C master with an 8-bit Wishbone register file.
// Optional CLK_STRETCH_EN: hold bit timing while a slave stretches SCL.
module i2c_master_wb #(
  parameter logic [15:0] PRER_RST = 16'hFFFF
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [2:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  input  logic       wb_cyc_i,
  output logic       wb_ack_o,
  output logic       wb_inta_o,
  input  logic       scl_pad_i,
  output logic       scl_pad_o,
  output logic       scl_padoen_o,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WRITE, S_READ, S_ACK, S_STOP
  } state_t;

  state_t      state;
  logic [15:0] prer;
  logic [15:0] cnt;
  logic [2:0]  ph;
  logic [2:0]  bitcnt;
  logic        en, ien;
  logic [7:0]  txr, rxr, shreg;
  logic        sta, sto, rd, wr, ack_cfg;
  logic        rxack, busy, al, tip, irq;
  logic        scl_oen, sda_oen;
  logic        scl_nx, sda_nx, scl_hi;
  logic        wb_req, wb_wr, cmd_go;
  logic        stall, tick, lost, fin;
  logic [7:0]  rdata;

  assign scl_pad_o    = 1'b0;
  assign sda_pad_o    = 1'b0;
  assign scl_padoen_o = scl_oen;
  assign sda_padoen_o = sda_oen;

  // Bus decode, tick generation, arbitration and end-of-command detection
  always_comb begin
    wb_req = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    wb_wr  = wb_req & wb_we_i;
    cmd_go = wb_wr && wb_adr_i == 3'd4 && en && !tip
             && |wb_dat_i[7:4];
`ifdef CLK_STRETCH_EN
    stall  = scl_oen & ~scl_pad_i;
`else
    stall  = 1'b0;
`endif
    tick   = state != S_IDLE && cnt == prer && !stall;
    lost   = scl_oen & scl_pad_i & sda_oen & ~sda_pad_i
             & ((state == S_START && ph == 3'd1)
             | (state == S_WRITE && ph == 3'd3));
    fin    = tick && ph == 3'd4
             && ((state == S_START && !wr && !rd && !sto)
             || (state == S_ACK && !sto)
             || state == S_STOP);
  end

  // Line levels wanted in the current phase of the current bit
  always_comb begin
    scl_hi = (ph == 3'd2) | (ph == 3'd3);
    scl_nx = scl_oen;
    sda_nx = sda_oen;
    unique case (state)
      S_START: begin
        scl_nx = ph != 3'd4;
        sda_nx = ph < 3'd2;
      end
      S_WRITE: begin
        scl_nx = scl_hi;
        sda_nx = shreg[7];
      end
      S_READ: begin
        scl_nx = scl_hi;
        sda_nx = 1'b1;
      end
      S_ACK: begin
        scl_nx = scl_hi;
        sda_nx = rd ? ack_cfg : 1'b1;
      end
      S_STOP: begin
        scl_nx = ph != 3'd0;
        sda_nx = ph >= 3'd3;
      end
      default: ;
    endcase
  end

  // Register read mux
  always_comb begin
    rdata = 8'h00;
    unique case (wb_adr_i)
      3'd0:    rdata = prer[7:0];
      3'd1:    rdata = prer[15:8];
      3'd2:    rdata = {en, ien, 6'b0};
      3'd3:    rdata = rxr;
      3'd4:    rdata = {rxack, busy, al, 3'b0, tip, irq};
      default: rdata = 8'h00;
    endcase
  end

  // Registers plus byte/bit sequencer
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state <= S_IDLE;
      prer <= PRER_RST;
      cnt <= '0;
      ph <= '0;
      bitcnt <= '0;
      {en, ien} <= 2'b00;
      txr <= '0;
      rxr <= '0;
      shreg <= '0;
      {sta, sto, rd, wr, ack_cfg} <= '0;
      {rxack, busy, al, tip, irq} <= '0;
      scl_oen <= 1'b1;
      sda_oen <= 1'b1;
    end else begin
      if (wb_wr) begin
        unique case (wb_adr_i)
          3'd0: prer[7:0] <= wb_dat_i;
          3'd1: prer[15:8] <= wb_dat_i;
          3'd2: {en, ien} <= wb_dat_i[7:6];
          3'd3: txr <= wb_dat_i;
          3'd4: if (wb_dat_i[0]) irq <= 1'b0;
          default: ;
        endcase
      end
      if (cmd_go) begin
        {sta, sto, rd, wr} <= wb_dat_i[7:4];
        ack_cfg <= wb_dat_i[3];
        tip <= 1'b1;
        al <= 1'b0;
        cnt <= '0;
        ph <= '0;
        bitcnt <= '0;
        shreg <= txr;
        if (wb_dat_i[7])      state <= S_START;
        else if (wb_dat_i[4]) state <= S_WRITE;
        else if (wb_dat_i[5]) state <= S_READ;
        else                  state <= S_STOP;
      end
      if (state != S_IDLE) begin
        if (!en) begin
          state <= S_IDLE;
          tip <= 1'b0;
          busy <= 1'b0;
          scl_oen <= 1'b1;
          sda_oen <= 1'b1;
          {sta, sto, rd, wr, ack_cfg} <= '0;
        end else if (lost) begin
          state <= S_IDLE;
          al <= 1'b1;
          irq <= 1'b1;
          tip <= 1'b0;
          scl_oen <= 1'b1;
          sda_oen <= 1'b1;
          {sta, sto, rd, wr, ack_cfg} <= '0;
        end else begin
          scl_oen <= scl_nx;
          sda_oen <= sda_nx;
          if (tick)        cnt <= '0;
          else if (!stall) cnt <= cnt + 16'd1;
          if (tick && ph == 3'd3) begin
            if (state == S_READ) rxr <= {rxr[6:0], sda_pad_i};
            if (state == S_ACK && wr) rxack <= sda_pad_i;
          end
          if (tick) begin
            ph <= (ph == 3'd4) ? 3'd0 : ph + 3'd1;
            if (ph == 3'd4) begin
              unique case (state)
                S_START: begin
                  busy <= 1'b1;
                  if (wr)       state <= S_WRITE;
                  else if (rd)  state <= S_READ;
                  else if (sto) state <= S_STOP;
                end
                S_WRITE: begin
                  shreg <= {shreg[6:0], 1'b0};
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == 3'd7) state <= S_ACK;
                end
                S_READ: begin
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == 3'd7) state <= S_ACK;
                end
                S_ACK:  if (sto) state <= S_STOP;
                S_STOP: busy <= 1'b0;
                default: ;
              endcase
            end
          end
          if (fin) begin
            state <= S_IDLE;
            tip <= 1'b0;
            irq <= 1'b1;
            {sta, sto, rd, wr, ack_cfg} <= '0;
          end
        end
      end
    end
  end

  // Wishbone handshake, registered read data and interrupt
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 8'h00;
      wb_inta_o <= 1'b0;
    end else begin
      wb_ack_o <= wb_req;
      wb_inta_o <= irq & ien;
      if (wb_req) wb_dat_o <= rdata;
    end
  end

endmodule

// File: tb/tb_i2c_master_wb.sv
// Bench for i2c_master_wb: Wishbone host, I2C slave/monitor model,
// directed spec scenarios plus randomized byte transfers.
module tb_i2c_master_wb;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic [2:0] adr;
  logic [7:0] dat_w;
  logic [7:0] dat_r;
  logic       we, stb, cyc_s;
  logic       ack, inta;
  logic       scl_o, scl_oen, sda_o, sda_oen;
  logic       scl_line, sda_line;

  int checks = 0;
  int errors = 0;

  logic       slave_rd = 1'b0;
  logic       slave_present = 1'b1;
  logic [7:0] slave_byte = 8'h00;
  logic       al_arm = 1'b0;
  logic       al_hit = 1'b0;
  logic       slave_sda = 1'b1;

  logic       bits[$];
  longint     rises[$];
  longint     cyc = 0;
  longint     hi_cyc = 0;
  logic       hi_bit = 1'b1;
  logic       had_high = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  int         pos = 0;
  int         starts = 0;
  int         stops = 0;

  i2c_master_wb dut (
    .wb_clk_i     (sys_clk),
    .wb_rst_i     (rst_n),
    .wb_adr_i     (adr),
    .wb_dat_i     (dat_w),
    .wb_dat_o     (dat_r),
    .wb_we_i      (we),
    .wb_stb_i     (stb),
    .wb_cyc_i     (cyc_s),
    .wb_ack_o     (ack),
    .wb_inta_o    (inta),
    .scl_pad_i    (scl_line),
    .scl_pad_o    (scl_o),
    .scl_padoen_o (scl_oen),
    .sda_pad_i    (sda_line),
    .sda_pad_o    (sda_o),
    .sda_padoen_o (sda_oen)
  );

  assign scl_line = scl_oen;
  assign sda_line = sda_oen & slave_sda & ~(al_arm & al_hit);

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic logic drive(int p);
    if (slave_rd) return (p < 8) ? slave_byte[7 - p] : 1'b1;
    return (p == 8 && slave_present) ? 1'b0 : 1'b1;
  endfunction

  always @(scl_line or sda_line) begin
    if (scl_line && prev_scl && prev_sda && !sda_line) begin
      starts++;
      pos = 0;
      had_high = 1'b0;
    end else if (scl_line && prev_scl && !prev_sda && sda_line) begin
      stops++;
      had_high = 1'b0;
    end else if (scl_line && !prev_scl) begin
      hi_bit = sda_line;
      hi_cyc = cyc;
      had_high = 1'b1;
    end else if (!scl_line && prev_scl) begin
      if (had_high) begin
        bits.push_back(hi_bit);
        rises.push_back(hi_cyc);
        pos = (pos == 8) ? 0 : pos + 1;
      end
      had_high = 1'b0;
      slave_sda = drive(pos);
      al_hit = (pos == 2);
    end
    prev_scl = scl_line;
    prev_sda = sda_line;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic [2:0] a, input logic [7:0] d,
                         input logic w, output logic [7:0] r);
    int n;
    @(negedge sys_clk);
    adr = a; dat_w = d; we = w; stb = 1'b1; cyc_s = 1'b1;
    n = 0;
    do begin
      @(posedge sys_clk); #1; n++;
    end while (!ack && n < 8);
    if (!ack) chk("wb_ack_timeout", {31'b0, ack}, 1);
    r = dat_r;
    stb = 1'b0; cyc_s = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] r;
    wb_xfer(a, d, 1'b1, r);
  endtask

  task automatic wb_rd(input logic [2:0] a, output logic [7:0] d);
    wb_xfer(a, 8'h00, 1'b0, d);
  endtask

  task automatic wait_done(output logic [7:0] sr);
    int n = 0;
    sr = 8'hFF;
    while (n < 4000) begin
      wb_rd(3'd4, sr);
      n++;
      if (!sr[1]) break;
    end
    chk("done_in_time", {31'b0, sr[1]}, 0);
  endtask

  function automatic logic [8:0] got9(int b);
    logic [8:0] v = '0;
    for (int i = 0; i < 9; i++)
      v = {v[7:0], (b + i < bits.size()) ? bits[b + i] : 1'b0};
    return v;
  endfunction

  function automatic longint period(int b);
    if (rises.size() < b + 2) return 0;
    return rises[b + 1] - rises[b];
  endfunction

  initial begin
    logic [7:0] r;
    logic [7:0] sr;
    int b, s0, p0;
    logic rxack_m;
    adr = '0; dat_w = '0; we = 0; stb = 0; cyc_s = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_scl_oen", {31'b0, scl_oen}, 1);
    chk("rst_sda_oen", {31'b0, sda_oen}, 1);
    chk("pad_o_zero", {30'b0, scl_o, sda_o}, 0);
    chk("rst_inta", {31'b0, inta}, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    @(negedge sys_clk);
    adr = 3'd0; we = 1'b0; stb = 1'b1; cyc_s = 1'b1;
    #1 chk("ack_before_edge", {31'b0, ack}, 0);
    @(posedge sys_clk); #1;
    chk("ack_one_cycle", {31'b0, ack}, 1);
    chk("rst_prer_lo", {24'b0, dat_r}, 8'hFF);
    @(negedge sys_clk);
    stb = 1'b0; cyc_s = 1'b0;
    @(posedge sys_clk); #1;
    chk("ack_pulse_end", {31'b0, ack}, 0);

    wb_rd(3'd1, r); chk("rst_prer_hi", {24'b0, r}, 8'hFF);
    wb_rd(3'd2, r); chk("rst_ctr", {24'b0, r}, 8'h00);
    wb_rd(3'd4, r); chk("rst_sr", {24'b0, r}, 8'h00);
    wb_rd(3'd3, r); chk("rst_rxr", {24'b0, r}, 8'h00);
    wb_wr(3'd5, 8'hFF);
    wb_rd(3'd5, r); chk("adr5_zero", {24'b0, r}, 8'h00);

    wb_wr(3'd0, 8'h27);
    wb_wr(3'd1, 8'h00);
    wb_rd(3'd0, r); chk("prer_lo_rw", {24'b0, r}, 8'h27);

    wb_wr(3'd2, 8'hC0);
    wb_wr(3'd3, 8'h18);
    slave_rd = 1'b0; slave_present = 1'b1;
    b = bits.size(); s0 = starts;
    wb_wr(3'd4, 8'h90);
    wb_rd(3'd4, r); chk("tip_set", {31'b0, r[1]}, 1);
    wait_done(sr);
    chk("wr_ack_sr", {24'b0, sr}, 8'h41);
    chk("wr_ack_inta", {31'b0, inta}, 1);
    chk("wr_ack_bits", {23'b0, got9(b)}, 9'h030);
    chk("wr_start_seen", starts - s0, 1);
    chk("scl_period_100k", period(b), 200);

    wb_wr(3'd4, 8'h01);
    wb_rd(3'd4, r); chk("iack_sr", {24'b0, r}, 8'h40);
    chk("iack_inta", {31'b0, inta}, 0);

    wb_wr(3'd0, 8'h03);
    slave_present = 1'b0;
    b = bits.size();
    wb_wr(3'd4, 8'h90);
    wait_done(sr);
    chk("wr_nack_sr", {24'b0, sr}, 8'hC1);
    chk("wr_nack_bits", {23'b0, got9(b)}, 9'h031);
    chk("scl_period_p3", period(b), 20);

    wb_wr(3'd4, 8'h01);
    slave_rd = 1'b1; slave_byte = 8'hA5;
    b = bits.size(); p0 = stops;
    wb_wr(3'd4, 8'h68);
    wait_done(sr);
    chk("rd_sr", {24'b0, sr}, 8'h81);
    wb_rd(3'd3, r); chk("rd_rxr", {24'b0, r}, 8'hA5);
    chk("rd_bits", {23'b0, got9(b)}, 9'h14B);
    chk("rd_stop_seen", stops - p0, 1);
    rxack_m = 1'b1;

    for (int it = 0; it < 10; it++) begin
      int p;
      logic is_rd, pres, nack;
      logic [7:0] by;
      logic [8:0] exp9;
      p = $urandom_range(0, 4);
      is_rd = 1'($urandom_range(0, 1));
      pres = 1'($urandom_range(0, 1));
      nack = 1'($urandom_range(0, 1));
      by = 8'($urandom_range(0, 255));
      wb_wr(3'd0, 8'(p));
      wb_wr(3'd4, 8'h01);
      slave_rd = is_rd; slave_present = pres; slave_byte = by;
      if (!is_rd) wb_wr(3'd3, by);
      b = bits.size(); s0 = starts; p0 = stops;
      wb_wr(3'd4, {2'b11, is_rd, !is_rd, nack, 3'b000});
      wait_done(sr);
      if (!is_rd) rxack_m = !pres;
      exp9 = is_rd ? {by, nack} : {by, !pres};
      chk("rnd_sr", {24'b0, sr}, {24'b0, rxack_m, 6'b0, 1'b1});
      chk("rnd_bits", {23'b0, got9(b)}, {23'b0, exp9});
      chk("rnd_period", period(b), 5 * (p + 1));
      chk("rnd_start_stop", {starts - s0, stops - p0}, {32'd1, 32'd1});
      if (is_rd) begin
        wb_rd(3'd3, r);
        chk("rnd_rxr", {24'b0, r}, {24'b0, by});
      end
    end

    wb_wr(3'd0, 8'h02);
    wb_wr(3'd4, 8'h01);
    slave_rd = 1'b0; slave_present = 1'b1;
    wb_wr(3'd3, 8'hFF);
    al_arm = 1'b1;
    wb_wr(3'd4, 8'h90);
    wait_done(sr);
    chk("al_sr", {24'b0, sr & 8'h23}, 8'h21);
    chk("al_release", {30'b0, scl_oen, sda_oen}, 2'b11);
    chk("al_inta", {31'b0, inta}, 1);
    al_arm = 1'b0;
    repeat (4) @(posedge sys_clk);

    wb_wr(3'd4, 8'h01);
    wb_wr(3'd4, 8'hD0);
    wait_done(sr);
    chk("al_cleared_sr", {24'b0, sr}, 8'h01);

    wb_wr(3'd4, 8'h01);
    wb_wr(3'd4, 8'h90);
    repeat (30) @(posedge sys_clk);
    wb_wr(3'd2, 8'h40);
    wb_rd(3'd4, r);
    chk("en_off_tip_if", {30'b0, r[1:0]}, 2'b00);
    chk("en_off_release", {30'b0, scl_oen, sda_oen}, 2'b11);
    repeat (100) @(posedge sys_clk);
    wb_wr(3'd4, 8'h90);
    wb_rd(3'd4, r);
    chk("en_off_cmd_ignored", {30'b0, r[1:0]}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
